aes_key_rev: RTL and testbench

- Reverse-direction AES-128 key schedule for the decryption datapath.
- Takes the cipher key and runs a forward expansion to reach round key K10, holding only 128 bits of key state.
- Each `next` request then steps one round back (K10 → K9 → … → K0) on the fly.
- Shares the single aes_sbox with the rest of the core through a request/word port pair; no 11-entry key RAM.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_key_step.sv | 54 +++++
 rtl/aes_key_rev.sv | 151 +++++++++++++++
 tb/tb_aes_key_rev.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES constants, key-schedule state encoding and small
//                GF(2^8) / word helpers used by the key-schedule blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int         AES_NROUNDS = 10;
    localparam logic [7:0] RCON_FIRST  = 8'h01;
    localparam logic [7:0] RCON_LAST   = 8'h36;

    // Key-schedule controller states.
    typedef enum logic [1:0] {
        KS_IDLE  = 2'd0,
        KS_FWD   = 2'd1,
        KS_READY = 2'd2,
        KS_STEP  = 2'd3
    } key_state_e;

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime8(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Divide by x in GF(2^8): undoes xtime8, used to walk rcon backwards.
    function automatic logic [7:0] inv_xtime8(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    // Cyclic left rotate by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_step
//  Description : Combinational single round of the AES-128 key schedule,
//                forward (dir=0) or reverse (dir=1).
//  Revision    : 1.0  initial release
//  Ports       : kreg_in   128  current round key {a,b,c,d}, a = [127:96]
//                rcon        8  round constant applied in this step
//                sub_word   32  SubWord(sbox_word) from the shared S-box
//                dir         1  0 = K(r) -> K(r+1), 1 = K(r) -> K(r-1)
//                kreg_out  128  resulting round key
//                sbox_word  32  word to present to the shared S-box
// ============================================================================
module aes_key_step (
    input  logic [127:0] kreg_in,
    input  logic [7:0]   rcon,
    input  logic [31:0]  sub_word,
    input  logic         dir,
    output logic [127:0] kreg_out,
    output logic [31:0]  sbox_word
);
    import aes_pkg::*;

    logic [31:0] a, b, c, d;
    logic [31:0] rot_sub;
    logic [31:0] a_n, b_n, c_n, d_n;

    assign a = kreg_in[127:96];
    assign b = kreg_in[95:64];
    assign c = kreg_in[63:32];
    assign d = kreg_in[31:0];

    // In reverse, the previous key's last word is d^c; that is what fed the
    // S-box when the forward schedule produced this key.
    assign sbox_word = dir ? (d ^ c) : d;
    assign rot_sub   = rot_word(sub_word);

    always_comb begin
        a_n = a ^ rot_sub ^ {rcon, 24'h0};
        b_n = b ^ a_n;
        c_n = c ^ b_n;
        d_n = d ^ c_n;
        if (dir) begin
            d_n = d ^ c;
            c_n = c ^ b;
            b_n = b ^ a;
            a_n = a ^ rot_sub ^ {rcon, 24'h0};
        end
    end

    assign kreg_out = {a_n, b_n, c_n, d_n};

endmodule : aes_key_step
`default_nettype wire

// File: rtl/aes_key_rev.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_rev
//  Description : Reverse-direction AES-128 key schedule. Expands the cipher
//                key forward to K10 using only 128 bits of state, then steps
//                back one round per `next` request. Borrows the core's
//                shared S-box through sbox_req/sboxw/new_sboxw.
//  Revision    : 1.0  initial release
//  Ports       : clk, reset_n (async, active-low)
//                key        128  cipher key, sampled on init
//                init             start forward expansion (highest priority)
//                next             step to previous round key (READY only)
//                rewind           restore K10 (READY only, beats next)
//                round_key  128  current round key (registered)
//                round        4  index of round_key
//                ready            round_key/round valid, block idle
//                sbox_req         block owns the shared S-box this cycle
//                sboxw       32  S-box input, 0 when sbox_req=0
//                new_sboxw   32  SubWord(sboxw) from the shared S-box
// ============================================================================
module aes_key_rev #(
    parameter logic [7:0] RCON_LAST = aes_pkg::RCON_LAST,
    parameter int         NROUNDS   = aes_pkg::AES_NROUNDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] key,
    input  logic         init,
    input  logic         next,
    input  logic         rewind,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         ready,
    output logic         sbox_req,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);
    import aes_pkg::*;

    key_state_e   state_q, state_d;
    logic [127:0] kreg_q, kreg_d;
    logic [127:0] k10_q, k10_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   round_q, round_d;
    logic         ready_q, ready_d;

    logic         step_dir;
    logic [127:0] step_kreg;
    logic [31:0]  step_sbox_word;

    aes_key_step u_step (
        .kreg_in   (kreg_q),
        .rcon      (rcon_q),
        .sub_word  (new_sboxw),
        .dir       (step_dir),
        .kreg_out  (step_kreg),
        .sbox_word (step_sbox_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= KS_IDLE;
            kreg_q  <= '0;
            k10_q   <= '0;
            rcon_q  <= RCON_FIRST;
            cnt_q   <= '0;
            round_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kreg_q  <= kreg_d;
            k10_q   <= k10_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kreg_d   = kreg_q;
        k10_d    = k10_q;
        rcon_d   = rcon_q;
        cnt_d    = cnt_q;
        round_d  = round_q;
        ready_d  = ready_q;
        sbox_req = 1'b0;
        step_dir = 1'b0;

        case (state_q)
            KS_IDLE: begin
                // Only init leaves IDLE; handled below.
            end
            KS_FWD: begin
                sbox_req = 1'b1;
                kreg_d   = step_kreg;
                rcon_d   = xtime8(rcon_q);
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'(NROUNDS - 1)) begin
                    // Last forward update: keep a copy of K10 so rewind
                    // never has to re-expand, and preload the K10 rcon.
                    k10_d   = step_kreg;
                    rcon_d  = RCON_LAST;
                    round_d = 4'(NROUNDS);
                    ready_d = 1'b1;
                    state_d = KS_READY;
                end
            end
            KS_READY: begin
                if (rewind) begin
                    kreg_d  = k10_q;
                    round_d = 4'(NROUNDS);
                    rcon_d  = RCON_LAST;
                end else if (next && (round_q != 4'd0)) begin
                    ready_d = 1'b0;
                    state_d = KS_STEP;
                end
            end
            KS_STEP: begin
                sbox_req = 1'b1;
                step_dir = 1'b1;
                kreg_d   = step_kreg;
                rcon_d   = inv_xtime8(rcon_q);
                round_d  = round_q - 4'd1;
                ready_d  = 1'b1;
                state_d  = KS_READY;
            end
            default: begin
                state_d = KS_IDLE;
            end
        endcase

        // init restarts from any state, abandoning whatever was in flight.
        if (init) begin
            kreg_d  = key;
            rcon_d  = RCON_FIRST;
            cnt_d   = '0;
            ready_d = 1'b0;
            state_d = KS_FWD;
        end
    end

    assign round_key = kreg_q;
    assign round     = round_q;
    assign ready     = ready_q;
    assign sboxw     = sbox_req ? step_sbox_word : 32'h0;

endmodule : aes_key_rev
`default_nettype wire

// File: tb/tb_aes_key_rev.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_rev
//  Description : Self-checking bench for aes_key_rev. Supplies the shared
//                S-box from a GF(2^8)-inverse model and compares every
//                round key against a plain FIPS-197 word-array expansion.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_key_rev;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] key;
    logic         init, next, rewind;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         ready, sbox_req;
    logic [31:0]  sboxw, new_sboxw;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    aes_key_rev dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .init      (init),
        .next      (next),
        .rewind    (rewind),
        .round_key (round_key),
        .round     (round),
        .ready     (ready),
        .sbox_req  (sbox_req),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] x);
        return 8'((x << 1) ^ (x[7] ? 8'h1b : 8'h00));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        for (int i = 1; i < 256; i++)
            if (gmul(b, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    assign new_sboxw = sub_word(sboxw);

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_init(input logic [127:0] k);
        key  = k;
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    // Edge count includes the edge that sampled init.
    task automatic wait_ready();
        int n  = 1;
        int sb = 0;
        while (!ready && n < 40) begin
            if (sbox_req) sb++;
            tick();
            n++;
        end
        check("init_latency", 128'(n), 128'd11);
        check("fwd_sbox_cycles", 128'(sb), 128'd10);
        check("k10_round", 128'(round), 128'd10);
    endtask

    task automatic do_next(input string tag);
        next = 1'b1;
        tick();
        next = 1'b0;
        check({tag, "_ready_low"}, 128'(ready), 128'd0);
        tick();
        check({tag, "_ready_high"}, 128'(ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        init    = 1'b0;
        next    = 1'b0;
        rewind  = 1'b0;
        key     = '0;
        tick();
        tick();
        check("rst_round_key", round_key, 128'h0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        check("rst_sbox_req", 128'(sbox_req), 128'd0);
        check("rst_sboxw", 128'(sboxw), 128'd0);
        reset_n = 1'b1;
        tick();

        // FIPS-197 known vector walk-down.
        build_model(FIPS_KEY);
        start_init(FIPS_KEY);
        wait_ready();
        check("fips_k10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_next("fips_k9");
        check("fips_k9_round", 128'(round), 128'd9);
        check("fips_k9", round_key, 128'hac7766f319fadc2128d12941575c006e);
        for (int r = 8; r >= 0; r--) begin
            do_next("walk");
            check("walk_round", 128'(round), 128'(r));
            check("walk_key", round_key, rk[r]);
            if (r == 1) check("fips_k1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        end
        check("fips_k0", round_key, FIPS_KEY);
        next = 1'b1;
        tick();
        next = 1'b0;
        check("r0_next_ready", 128'(ready), 128'd1);
        tick();
        check("r0_next_round", 128'(round), 128'd0);
        check("r0_next_key", round_key, FIPS_KEY);

        // Rewind from round 3, then confirm rcon was reloaded by stepping.
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        for (int r = 9; r >= 3; r--) do_next("to_r3");
        check("at_r3", 128'(round), 128'd3);
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        check("rewind_ready", 128'(ready), 128'd1);
        check("rewind_round", 128'(round), 128'd10);
        check("rewind_key", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_next("after_rewind");
        check("after_rewind_k9", round_key, 128'hac7766f319fadc2128d12941575c006e);

        // Random keys with random next / rewind / idle traffic.
        for (int k = 0; k < 4; k++) begin
            logic [127:0] rkey;
            int exp_round;
            rkey = {$urandom, $urandom, $urandom, $urandom};
            build_model(rkey);
            start_init(rkey);
            wait_ready();
            check("rnd_k10", round_key, rk[10]);
            exp_round = 10;
            for (int op = 0; op < 20; op++) begin
                int sel;
                sel = int'($urandom_range(0, 7));
                if (sel == 0) begin
                    rewind = 1'b1;
                    next   = 1'($urandom_range(0, 1));
                    tick();
                    rewind = 1'b0;
                    next   = 1'b0;
                    exp_round = 10;
                end else if (sel == 1) begin
                    tick();
                end else begin
                    next = 1'b1;
                    tick();
                    next = 1'b0;
                    if (exp_round > 0) begin
                        check("rnd_ready_low", 128'(ready), 128'd0);
                        tick();
                        exp_round--;
                    end
                end
                check("rnd_ready", 128'(ready), 128'd1);
                check("rnd_round", 128'(round), 128'(exp_round));
                check("rnd_key", round_key, rk[exp_round]);
            end
        end

        // init on the 5th forward cycle restarts with the new key.
        key  = FIPS_KEY;
        init = 1'b1;
        tick();
        init = 1'b0;
        repeat (4) tick();
        start_init(SEQ_KEY);
        wait_ready();
        check("restart_k10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        do_next("restart_step");
        next   = 1'b1;
        rewind = 1'b1;
        tick();
        next   = 1'b0;
        rewind = 1'b0;
        check("both_ready", 128'(ready), 128'd1);
        check("both_round", 128'(round), 128'd10);
        check("both_key", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Asynchronous reset while stepping.
        next = 1'b1;
        tick();
        next = 1'b0;
        check("in_step_sbox_req", 128'(sbox_req), 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_round_key", round_key, 128'h0);
        check("arst_round", 128'(round), 128'd0);
        check("arst_ready", 128'(ready), 128'd0);
        check("arst_sbox_req", 128'(sbox_req), 128'd0);
        check("arst_sboxw", 128'(sboxw), 128'd0);
        tick();
        reset_n = 1'b1;
        next    = 1'b1;
        tick();
        tick();
        next = 1'b0;
        check("idle_next_ready", 128'(ready), 128'd0);
        check("idle_next_round", 128'(round), 128'd0);
        check("idle_next_sbox_req", 128'(sbox_req), 128'd0);
        check("idle_next_key", round_key, 128'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_aes_key_rev
`default_nettype wire
